// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: registers the decoded bundle into EX,
// detects load-use hazards (one-cycle stall plus bubble) and squashes ID on a redirect.
module id_ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid_in,
    input  logic [XLEN-1:0] id_pc_in,
    input  logic [XLEN-1:0] id_rs1_data_in,
    input  logic [XLEN-1:0] id_rs2_data_in,
    input  logic [XLEN-1:0] id_imm_in,
    input  logic [4:0]      id_rs1_in,
    input  logic [4:0]      id_rs2_in,
    input  logic [4:0]      id_rd_in,
    input  logic [2:0]      id_funct3_in,
    input  logic            id_funct7b5_in,
    input  logic            mem_rd_in,
    input  logic            mem_wr_in,
    input  logic            reg_wr_in,
    input  logic            mux_reg_wr_in,
    input  logic            mux_ula_in,
    input  logic            pc_ula_in,
    input  logic            jump_in,
    input  logic            branch_in,
    input  logic            jalr_in,
    input  logic [1:0]      ula_op_in,
    input  logic            flush_in,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic            ex_reg_wr,
    output logic            ex_mux_reg_wr,
    output logic            ex_mux_ula,
    output logic            ex_pc_ula,
    output logic            ex_jump,
    output logic            ex_branch,
    output logic            ex_jalr,
    output logic [1:0]      ex_ula_op,
    output logic            stall_out,
    output logic [31:0]     stall_cnt
);

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [XLEN-1:0] ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0] ex_rs2_data_q, ex_rs2_data_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic [4:0]      ex_rs1_q, ex_rs1_d;
    logic [4:0]      ex_rs2_q, ex_rs2_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic [2:0]      ex_funct3_q, ex_funct3_d;
    logic            ex_funct7b5_q, ex_funct7b5_d;
    logic            ex_mem_rd_q, ex_mem_rd_d;
    logic            ex_mem_wr_q, ex_mem_wr_d;
    logic            ex_reg_wr_q, ex_reg_wr_d;
    logic            ex_mux_reg_wr_q, ex_mux_reg_wr_d;
    logic            ex_mux_ula_q, ex_mux_ula_d;
    logic            ex_pc_ula_q, ex_pc_ula_d;
    logic            ex_jump_q, ex_jump_d;
    logic            ex_branch_q, ex_branch_d;
    logic            ex_jalr_q, ex_jalr_d;
    logic [1:0]      ex_ula_op_q, ex_ula_op_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    logic use_rs1;
    logic use_rs2;
    logic hazard;
    logic load;

    // LUI/AUIPC/JAL ignore rs1; only R/S/B-type read rs2.
    always_comb begin
        use_rs1 = id_valid_in & (~pc_ula_in | jalr_in);
        use_rs2 = id_valid_in & (~mux_ula_in | mem_wr_in | branch_in);
        hazard  = ex_valid_q & ex_mem_rd_q & (ex_rd_q != 5'd0) &
                  ((use_rs1 & (ex_rd_q == id_rs1_in)) | (use_rs2 & (ex_rd_q == id_rs2_in)));
    end

    assign stall_out = hazard & ~flush_in;
    assign load      = ~flush_in & ~stall_out;

    always_comb begin
        ex_valid_d      = 1'b0;
        ex_pc_d         = '0;
        ex_rs1_data_d   = '0;
        ex_rs2_data_d   = '0;
        ex_imm_d        = '0;
        ex_rs1_d        = 5'd0;
        ex_rs2_d        = 5'd0;
        ex_rd_d         = 5'd0;
        ex_funct3_d     = 3'd0;
        ex_funct7b5_d   = 1'b0;
        ex_mem_rd_d     = 1'b0;
        ex_mem_wr_d     = 1'b0;
        ex_reg_wr_d     = 1'b0;
        ex_mux_reg_wr_d = 1'b0;
        ex_mux_ula_d    = 1'b0;
        ex_pc_ula_d     = 1'b0;
        ex_jump_d       = 1'b0;
        ex_branch_d     = 1'b0;
        ex_jalr_d       = 1'b0;
        ex_ula_op_d     = 2'b00;
        if (load) begin
            ex_valid_d      = id_valid_in;
            ex_pc_d         = id_pc_in;
            ex_rs1_data_d   = id_rs1_data_in;
            ex_rs2_data_d   = id_rs2_data_in;
            ex_imm_d        = id_imm_in;
            ex_rs1_d        = id_rs1_in;
            ex_rs2_d        = id_rs2_in;
            ex_rd_d         = id_rd_in;
            ex_funct3_d     = id_funct3_in;
            ex_funct7b5_d   = id_funct7b5_in;
            ex_mem_rd_d     = id_valid_in & mem_rd_in;
            ex_mem_wr_d     = id_valid_in & mem_wr_in;
            // Branches and x0 destinations never write back.
            ex_reg_wr_d     = id_valid_in & reg_wr_in & ~branch_in & (id_rd_in != 5'd0);
            ex_mux_reg_wr_d = id_valid_in & mux_reg_wr_in;
            ex_mux_ula_d    = id_valid_in & mux_ula_in;
            ex_pc_ula_d     = id_valid_in & pc_ula_in;
            ex_jump_d       = id_valid_in & jump_in;
            ex_branch_d     = id_valid_in & branch_in;
            ex_jalr_d       = id_valid_in & jalr_in;
            ex_ula_op_d     = id_valid_in ? ula_op_in : 2'b00;
        end
        stall_cnt_d = stall_out ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q      <= 1'b0;
            ex_pc_q         <= '0;
            ex_rs1_data_q   <= '0;
            ex_rs2_data_q   <= '0;
            ex_imm_q        <= '0;
            ex_rs1_q        <= 5'd0;
            ex_rs2_q        <= 5'd0;
            ex_rd_q         <= 5'd0;
            ex_funct3_q     <= 3'd0;
            ex_funct7b5_q   <= 1'b0;
            ex_mem_rd_q     <= 1'b0;
            ex_mem_wr_q     <= 1'b0;
            ex_reg_wr_q     <= 1'b0;
            ex_mux_reg_wr_q <= 1'b0;
            ex_mux_ula_q    <= 1'b0;
            ex_pc_ula_q     <= 1'b0;
            ex_jump_q       <= 1'b0;
            ex_branch_q     <= 1'b0;
            ex_jalr_q       <= 1'b0;
            ex_ula_op_q     <= 2'b00;
            stall_cnt_q     <= 32'd0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_pc_q         <= ex_pc_d;
            ex_rs1_data_q   <= ex_rs1_data_d;
            ex_rs2_data_q   <= ex_rs2_data_d;
            ex_imm_q        <= ex_imm_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_rd_q         <= ex_rd_d;
            ex_funct3_q     <= ex_funct3_d;
            ex_funct7b5_q   <= ex_funct7b5_d;
            ex_mem_rd_q     <= ex_mem_rd_d;
            ex_mem_wr_q     <= ex_mem_wr_d;
            ex_reg_wr_q     <= ex_reg_wr_d;
            ex_mux_reg_wr_q <= ex_mux_reg_wr_d;
            ex_mux_ula_q    <= ex_mux_ula_d;
            ex_pc_ula_q     <= ex_pc_ula_d;
            ex_jump_q       <= ex_jump_d;
            ex_branch_q     <= ex_branch_d;
            ex_jalr_q       <= ex_jalr_d;
            ex_ula_op_q     <= ex_ula_op_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc         = ex_pc_q;
    assign ex_rs1_data   = ex_rs1_data_q;
    assign ex_rs2_data   = ex_rs2_data_q;
    assign ex_imm        = ex_imm_q;
    assign ex_rs1        = ex_rs1_q;
    assign ex_rs2        = ex_rs2_q;
    assign ex_rd         = ex_rd_q;
    assign ex_funct3     = ex_funct3_q;
    assign ex_funct7b5   = ex_funct7b5_q;
    assign ex_mem_rd     = ex_mem_rd_q;
    assign ex_mem_wr     = ex_mem_wr_q;
    assign ex_reg_wr     = ex_reg_wr_q;
    assign ex_mux_reg_wr = ex_mux_reg_wr_q;
    assign ex_mux_ula    = ex_mux_ula_q;
    assign ex_pc_ula     = ex_pc_ula_q;
    assign ex_jump       = ex_jump_q;
    assign ex_branch     = ex_branch_q;
    assign ex_jalr       = ex_jalr_q;
    assign ex_ula_op     = ex_ula_op_q;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: per-step expected EX contents are queued when ID is
// driven and popped after the clock edge; also covers reset, flush priority and wrap.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic        mux_reg_wr;
        logic        mux_ula;
        logic        pc_ula;
        logic        jump;
        logic        branch;
        logic        jalr;
        logic [1:0]  ula_op;
    } stage_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush_in = 1'b0;
    stage_t      id = '0;
    stage_t      obs;

    logic        id_valid_in, id_funct7b5_in;
    logic [31:0] id_pc_in, id_rs1_data_in, id_rs2_data_in, id_imm_in;
    logic [4:0]  id_rs1_in, id_rs2_in, id_rd_in;
    logic [2:0]  id_funct3_in;
    logic        mem_rd_in, mem_wr_in, reg_wr_in, mux_reg_wr_in, mux_ula_in;
    logic        pc_ula_in, jump_in, branch_in, jalr_in;
    logic [1:0]  ula_op_in;

    logic        ex_valid, ex_funct7b5;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr, ex_mux_ula;
    logic        ex_pc_ula, ex_jump, ex_branch, ex_jalr;
    logic [1:0]  ex_ula_op;
    logic        stall_out;
    logic [31:0] stall_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_cnt = 32'd0;
    stage_t      exp_q[$];

    assign {id_valid_in, id_pc_in, id_rs1_data_in, id_rs2_data_in, id_imm_in, id_rs1_in,
            id_rs2_in, id_rd_in, id_funct3_in, id_funct7b5_in, mem_rd_in, mem_wr_in,
            reg_wr_in, mux_reg_wr_in, mux_ula_in, pc_ula_in, jump_in, branch_in, jalr_in,
            ula_op_in} = id;

    assign obs = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                  ex_funct3, ex_funct7b5, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr,
                  ex_mux_ula, ex_pc_ula, ex_jump, ex_branch, ex_jalr, ex_ula_op};

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_in    (id_valid_in),
        .id_pc_in       (id_pc_in),
        .id_rs1_data_in (id_rs1_data_in),
        .id_rs2_data_in (id_rs2_data_in),
        .id_imm_in      (id_imm_in),
        .id_rs1_in      (id_rs1_in),
        .id_rs2_in      (id_rs2_in),
        .id_rd_in       (id_rd_in),
        .id_funct3_in   (id_funct3_in),
        .id_funct7b5_in (id_funct7b5_in),
        .mem_rd_in      (mem_rd_in),
        .mem_wr_in      (mem_wr_in),
        .reg_wr_in      (reg_wr_in),
        .mux_reg_wr_in  (mux_reg_wr_in),
        .mux_ula_in     (mux_ula_in),
        .pc_ula_in      (pc_ula_in),
        .jump_in        (jump_in),
        .branch_in      (branch_in),
        .jalr_in        (jalr_in),
        .ula_op_in      (ula_op_in),
        .flush_in       (flush_in),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_rs1_data    (ex_rs1_data),
        .ex_rs2_data    (ex_rs2_data),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd),
        .ex_funct3      (ex_funct3),
        .ex_funct7b5    (ex_funct7b5),
        .ex_mem_rd      (ex_mem_rd),
        .ex_mem_wr      (ex_mem_wr),
        .ex_reg_wr      (ex_reg_wr),
        .ex_mux_reg_wr  (ex_mux_reg_wr),
        .ex_mux_ula     (ex_mux_ula),
        .ex_pc_ula      (ex_pc_ula),
        .ex_jump        (ex_jump),
        .ex_branch      (ex_branch),
        .ex_jalr        (ex_jalr),
        .ex_ula_op      (ex_ula_op),
        .stall_out      (stall_out),
        .stall_cnt      (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_ex(input string tag, input stage_t e);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    function automatic stage_t ins(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [31:0] imm);
        stage_t s = '0;
        s.valid    = 1'b1;
        s.pc       = $urandom() & 32'hFFFF_FFFC;
        s.rs1_data = $urandom();
        s.rs2_data = $urandom();
        s.imm      = imm;
        s.rs1      = rs1;
        s.rs2      = rs2;
        s.rd       = rd;
        return s;
    endfunction

    function automatic stage_t lw(input logic [4:0] rd, input logic [4:0] rs1);
        stage_t s = ins(rd, rs1, 5'd0, 32'd0);
        s.funct3 = 3'b010; s.mem_rd = 1'b1; s.reg_wr = 1'b1; s.mux_reg_wr = 1'b1;
        s.mux_ula = 1'b1;
        return s;
    endfunction

    function automatic stage_t add(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2);
        stage_t s = ins(rd, rs1, rs2, 32'd0);
        s.reg_wr = 1'b1; s.ula_op = 2'b10;
        return s;
    endfunction

    // Expected EX contents after a normal load of x.
    function automatic stage_t expect_load(input stage_t x);
        stage_t e = x;
        if (!x.valid) begin
            e.mem_rd = 1'b0; e.mem_wr = 1'b0; e.mux_reg_wr = 1'b0; e.mux_ula = 1'b0;
            e.pc_ula = 1'b0; e.jump = 1'b0; e.branch = 1'b0; e.jalr = 1'b0;
            e.ula_op = 2'b00;
        end
        e.reg_wr = x.valid & x.reg_wr & ~x.branch & (x.rd != 5'd0);
        return e;
    endfunction

    task automatic step(input string tag, input stage_t x, input logic f, input logic exp_stall);
        stage_t e;
        @(negedge clk);
        id = x;
        flush_in = f;
        #1;
        chk({tag, "/stall"}, {31'd0, stall_out}, {31'd0, exp_stall});
        e = (f || exp_stall) ? stage_t'('0) : expect_load(x);
        exp_q.push_back(e);
        if (exp_stall) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
        chk_ex({tag, "/ex"}, exp_q.pop_front());
        chk({tag, "/cnt"}, stall_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        stage_t s;
        #1 rst_n = 1'b0;
        #2;
        chk_ex("reset0/ex", stage_t'('0));
        chk("reset0/cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use on rs1: one stall, bubble, then the add.
        step("lw_x5", lw(5'd5, 5'd1), 1'b0, 1'b0);
        s = add(5'd6, 5'd5, 5'd2);
        step("add_stall", s, 1'b0, 1'b1);
        chk("add_stall/bubble", {31'd0, ex_valid}, 32'd0);
        step("add_held", s, 1'b0, 1'b0);
        chk("add_held/rd", {27'd0, ex_rd}, 32'd6);
        chk("add_held/reg_wr", {31'd0, ex_reg_wr}, 32'd1);
        chk("add_held/ula_op", {30'd0, ex_ula_op}, 32'd2);
        chk("add_held/cnt", stall_cnt, 32'd1);

        // No false stalls.
        step("lw_x0", lw(5'd0, 5'd1), 1'b0, 1'b0);
        step("add_x0", add(5'd6, 5'd0, 5'd0), 1'b0, 1'b0);
        step("lw_x5b", lw(5'd5, 5'd1), 1'b0, 1'b0);
        s = ins(5'd5, 5'd5, 5'd5, 32'h1234_5000);
        s.reg_wr = 1'b1; s.mux_ula = 1'b1; s.pc_ula = 1'b1;
        step("lui", s, 1'b0, 1'b0);
        step("lw_x5c", lw(5'd5, 5'd1), 1'b0, 1'b0);
        s = ins(5'd7, 5'd1, 5'd5, 32'd4);
        s.reg_wr = 1'b1; s.mux_ula = 1'b1; s.ula_op = 2'b11;
        step("addi", s, 1'b0, 1'b0);

        // Store data dependency stalls.
        step("lw_x5d", lw(5'd5, 5'd1), 1'b0, 1'b0);
        s = ins(5'd0, 5'd1, 5'd5, 32'd0);
        s.funct3 = 3'b010; s.mem_wr = 1'b1; s.mux_ula = 1'b1;
        step("sw_stall", s, 1'b0, 1'b1);
        step("sw_held", s, 1'b0, 1'b0);

        // Branch never writes back.
        s = ins(5'd8, 5'd3, 5'd4, 32'd16);
        s.branch = 1'b1; s.reg_wr = 1'b1; s.ula_op = 2'b01;
        step("beq", s, 1'b0, 1'b0);
        chk("beq/reg_wr", {31'd0, ex_reg_wr}, 32'd0);
        chk("beq/branch", {31'd0, ex_branch}, 32'd1);

        // Flush beats a hazard in the same cycle.
        step("lw_x5e", lw(5'd5, 5'd1), 1'b0, 1'b0);
        step("flush_hazard", add(5'd6, 5'd5, 5'd2), 1'b1, 1'b0);

        // Flush in the cycle after a stall squashes the held instruction.
        step("lw_x5f", lw(5'd5, 5'd1), 1'b0, 1'b0);
        s = add(5'd6, 5'd5, 5'd2);
        step("stall_then", s, 1'b0, 1'b1);
        step("flush_held", s, 1'b1, 1'b0);

        // Invalid ID slot loads all control bits as zero.
        s = add(5'd9, 5'd1, 5'd2);
        s.valid = 1'b0; s.mem_rd = 1'b1; s.jump = 1'b1;
        step("invalid", s, 1'b0, 1'b0);

        // Counter wrap.
        step("lw_x5g", lw(5'd5, 5'd1), 1'b0, 1'b0);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt_q;
        #1;
        exp_cnt = 32'hFFFF_FFFF;
        chk("preset/cnt", stall_cnt, 32'hFFFF_FFFF);
        s = add(5'd6, 5'd5, 5'd2);
        step("wrap_stall", s, 1'b0, 1'b1);
        chk("wrap/cnt", stall_cnt, 32'd0);
        step("wrap_held", s, 1'b0, 1'b0);

        // Asynchronous reset with a load in EX and a dependent add in ID.
        step("lw_x5h", lw(5'd5, 5'd1), 1'b0, 1'b0);
        id = add(5'd6, 5'd5, 5'd2);
        #1;
        chk("pre_rst/mem_rd", {31'd0, ex_mem_rd}, 32'd1);
        chk("pre_rst/stall", {31'd0, stall_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_ex("rst_mid/ex", stage_t'('0));
        chk("rst_mid/stall", {31'd0, stall_out}, 32'd0);
        chk("rst_mid/cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 32'd0;
        step("post_rst", add(5'd6, 5'd5, 5'd2), 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline boundary of the RV32I core. Each cycle it registers the decoded control bundle, operands, immediate and register indices from the ID stage into the EX stage. It detects load-use hazards and answers them by stalling the PC and IF/ID and injecting a one-cycle bubble. It squashes the ID instruction on an EX-resolved redirect (`flush_in`).

## Interface
- `XLEN`, default 32: datapath width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid_in`  in  1  ID slot holds a real instruction.
- `id_pc_in`, `id_rs1_data_in`, `id_rs2_data_in`, `id_imm_in`  in  XLEN each  PC, register-file read data, sign-extended immediate.
- `id_rs1_in`, `id_rs2_in`, `id_rd_in`  in  5 each  register indices.
- `id_funct3_in`  in  3; `id_funct7b5_in`  in  1  ALU/branch/memory sub-op bits.
- `mem_rd_in`, `mem_wr_in`, `reg_wr_in`, `mux_reg_wr_in`, `mux_ula_in`, `pc_ula_in`, `jump_in`, `branch_in`, `jalr_in`  in  1 each  decoder outputs.
- `ula_op_in`  in  2  decoder ALU class.
- `flush_in`  in  1  EX taken branch/jump; squash the instruction currently in ID.
- `ex_valid`  out  1  EX slot holds a real instruction.
- `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`  out  XLEN each  registered copies.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5 each.
- `ex_funct3`  out  3; `ex_funct7b5`  out  1.
- `ex_mem_rd`, `ex_mem_wr`, `ex_reg_wr`, `ex_mux_reg_wr`, `ex_mux_ula`, `ex_pc_ula`, `ex_jump`, `ex_branch`, `ex_jalr`  out  1 each.
- `ex_ula_op`  out  2.
- `stall_out`  out  1  combinational; holds the PC and IF/ID this cycle.
- `stall_cnt`  out  32  number of cycles in which `stall_out` was 1; wraps modulo 2^32.

## Operation
- **Source usage.** Computed from the ID inputs.
  - `use_rs1` = `id_valid_in & (!pc_ula_in | jalr_in)`. LUI, AUIPC and JAL do not read rs1.
  - `use_rs2` = `id_valid_in & (!mux_ula_in | mem_wr_in | branch_in)`. R-type, S-type and B-type read rs2.
- **Hazard.** `hazard` = `ex_valid & ex_mem_rd & (ex_rd != 0) & ((use_rs1 & ex_rd == id_rs1_in) | (use_rs2 & ex_rd == id_rs2_in))`.
- **Stall output.** `stall_out` = `hazard & !flush_in`.
- **Per-edge update, highest priority first:**
  - **Flush** (`flush_in` = 1): load a bubble. This applies even when `hazard` = 1.
  - **Stall** (`stall_out` = 1): load a bubble. The upstream stages hold, so the same ID instruction is presented again next cycle.
  - **Load** (otherwise): register all ID inputs. `ex_valid` = `id_valid_in`.
- **Bubble.** `ex_valid` and all `ex_*` control bits are 0. All data, index and funct fields are 0.
- **Load-time control rules.**
  - If `id_valid_in` = 0, every control bit is loaded as 0.
  - `ex_reg_wr` = `reg_wr_in & !branch_in & (id_rd_in != 0)`. B-type instructions and x0 never produce a writeback.
- **Stall counter.** `stall_cnt` increments by 1 on every edge at which `stall_out` = 1. After 0xFFFFFFFF it wraps to 0.

## Timing
- **Reset.** While `rst_n` = 0, every registered output is 0 immediately, without waiting for a clock edge. This includes `ex_valid`, all control bits, all data fields and `stall_cnt`. Consequently `stall_out` = 0.
- **Latency.** Exactly 1 cycle from ID inputs to `ex_*` outputs.
- **Load-use stall length.** Exactly one cycle.
  - The bubble clears `ex_mem_rd`, so `stall_out` drops in the following cycle.
  - The dependent instruction reaches EX two cycles after the load reached EX.
- **Stall followed by flush.** If a flush arrives in the cycle after a stall, the held instruction is squashed. It never reaches EX.
- **Reset during a stall or flush.** Reset overrides both. The first edge after `rst_n` rises performs a normal load.
- **Combinational depth.** `stall_out` depends only on the ID inputs, the registered EX fields and `flush_in`. There is no path from the `ex_*` outputs back into the `ex_*` registers other than the stall feedback.

## Test plan
- **Reset.** Assert `rst_n` = 0 mid-stream with `ex_valid` = 1 and `ex_mem_rd` = 1 → all outputs are 0 before the next edge, `stall_out` = 0, `stall_cnt` = 0.
- **Load-use stall.** `lw x5, 0(x1)` is followed by `add x6, x5, x2` (rs1 = 5, rs2 = 2, `mux_ula_in` = 0).
  - Expected: one cycle with `stall_out` = 1, then a bubble in EX (`ex_valid` = 0).
  - Next cycle: `ex_rd` = 6, `ex_reg_wr` = 1, `ex_ula_op` = 2'b10. `stall_cnt` = 1.
- **No false stalls.**
  - `lw x0, …` followed by `add x6, x0, x0` → no stall.
  - `lw x5` followed by `lui x5, 0x12345` (`pc_ula_in` = 1, `jalr_in` = 0) → no stall.
  - `lw x5` followed by `addi x7, x1, 4` with `id_rs2_in` = 5 (`use_rs2` = 0) → no stall.
- **Store and branch dependencies.**
  - `lw x5` followed by `sw x5, 0(x1)` (rs2 = 5, `mem_wr_in` = 1) → stall.
  - `beq x3, x4` loaded with `reg_wr_in` = 1 and `branch_in` = 1 → `ex_reg_wr` = 0, `ex_branch` = 1.
- **Flush priority.** `flush_in` = 1 in the same cycle that `hazard` = 1 → `stall_out` = 0, next `ex_valid` = 0, `stall_cnt` unchanged.
- **Counter wrap.** Preset `stall_cnt` to 0xFFFFFFFF via a forced stall sequence, then apply one stall → `stall_cnt` = 0x00000000.
